time_set_ctrl: RTL and testbench

TIME_SET_CTRL -- requirements
Module: time_set_ctrl

---
 rtl/time_set_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_time_set_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/time_set_ctrl.sv
// -----------------------------------------------------------------------------
// time_set_ctrl
//
// Button front end and set-mode state machine for a clock display.
// Two push buttons are synchronized, debounced on frame boundaries and turned
// into press events. The mode button cycles RUN -> SET_HRS -> SET_MIN ->
// SET_SEC -> RUN. In a set state the inc button emits increment pulses to the
// timekeeper, with auto-repeat while held. The selected field blinks, and the
// set state times out back to RUN after a period with no button activity.
//
// Ports
//   px_clk       in   pixel clock, all logic on the rising edge
//   reset        in   synchronous, active-high
//   frame_en     in   one-cycle pulse per frame
//   btn_mode     in   asynchronous mode button, active-high
//   btn_inc      in   asynchronous increment button, active-high
//   mode         out  [1:0] 0 RUN, 1 SET_HRS, 2 SET_MIN, 3 SET_SEC
//   hold_tick    out  high in any set state (freezes the seconds prescaler)
//   inc_hrs      out  one-cycle hours increment pulse
//   inc_min      out  one-cycle minutes increment pulse
//   inc_sec      out  one-cycle seconds increment pulse
//   field_blank  out  [2:0] blank mask {hrs,min,sec}
// -----------------------------------------------------------------------------
module time_set_ctrl #(
    parameter int DEBOUNCE_FRAMES = 2,
    parameter int REPEAT_DELAY    = 30,
    parameter int REPEAT_RATE     = 8,
    parameter int TIMEOUT_FRAMES  = 1800,
    parameter int BLINK_HALF      = 18
) (
    input  logic       px_clk,
    input  logic       reset,
    input  logic       frame_en,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [1:0] mode,
    output logic       hold_tick,
    output logic       inc_hrs,
    output logic       inc_min,
    output logic       inc_sec,
    output logic [2:0] field_blank
);

    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int DB_W    = $clog2(DEBOUNCE_FRAMES) + 1;
    localparam int REP_W   = $clog2(REP_MAX) + 1;
    localparam int TO_W    = $clog2(TIMEOUT_FRAMES) + 1;
    localparam int BL_W    = $clog2(BLINK_HALF) + 1;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_HRS = 2'd1,
        SET_MIN = 2'd2,
        SET_SEC = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [1:0]        mode_sync;
    logic [1:0]        inc_sync;
    logic              mode_db;
    logic              inc_db;
    logic [DB_W-1:0]   mode_db_cnt;
    logic [DB_W-1:0]   inc_db_cnt;

    logic              mode_flip;
    logic              inc_flip;
    logic              mode_db_nxt;
    logic              inc_db_nxt;
    logic              mode_rise;
    logic              inc_rise;

    logic              inc_active;
    logic              rep_armed;
    logic [REP_W-1:0]  rep_cnt;
    logic [TO_W-1:0]   idle_cnt;
    logic [BL_W-1:0]   blink_cnt;
    logic              phase;

    logic              timeout;
    logic              state_chg;
    logic              inc_press_ok;
    logic              rep_hit;
    logic              rep_fire;
    logic              inc_fire;
    logic              blink_hit;
    logic              phase_nxt;
    logic [2:0]        field_sel;
    logic [2:0]        field_blank_nxt;

    assign mode = state;

    always_ff @(posedge px_clk) begin
        if (reset) begin
            mode_sync <= 2'b00;
            inc_sync  <= 2'b00;
        end else begin
            mode_sync <= {mode_sync[0], btn_mode};
            inc_sync  <= {inc_sync[0], btn_inc};
        end
    end

    // A debounced level flips on the frame where the run of differing
    // samples reaches DEBOUNCE_FRAMES; the rise is the press event, which is
    // registered by every consumer at that same edge.
    always_comb begin
        mode_flip   = frame_en && (mode_sync[1] != mode_db) &&
                      (mode_db_cnt == DB_W'(DEBOUNCE_FRAMES - 1));
        inc_flip    = frame_en && (inc_sync[1] != inc_db) &&
                      (inc_db_cnt == DB_W'(DEBOUNCE_FRAMES - 1));
        mode_db_nxt = mode_db ^ mode_flip;
        inc_db_nxt  = inc_db ^ inc_flip;
        mode_rise   = mode_flip && !mode_db;
        inc_rise    = inc_flip && !inc_db;
    end

    always_ff @(posedge px_clk) begin
        if (reset) begin
            mode_db     <= 1'b0;
            inc_db      <= 1'b0;
            mode_db_cnt <= '0;
            inc_db_cnt  <= '0;
        end else if (frame_en) begin
            mode_db <= mode_db_nxt;
            inc_db  <= inc_db_nxt;
            if ((mode_sync[1] == mode_db) || mode_flip)
                mode_db_cnt <= '0;
            else
                mode_db_cnt <= mode_db_cnt + DB_W'(1);
            if ((inc_sync[1] == inc_db) || inc_flip)
                inc_db_cnt <= '0;
            else
                inc_db_cnt <= inc_db_cnt + DB_W'(1);
        end
    end

    // Next-state and pulse decisions. A mode press or timeout changes the
    // state and suppresses any inc activity in that same cycle; a held inc
    // only repeats if its press was accepted in the current state.
    always_comb begin
        timeout = (idle_cnt == TO_W'(TIMEOUT_FRAMES));

        state_nxt = state;
        if (mode_rise) begin
            case (state)
                RUN:     state_nxt = SET_HRS;
                SET_HRS: state_nxt = SET_MIN;
                SET_MIN: state_nxt = SET_SEC;
                default: state_nxt = RUN;
            endcase
        end else if (timeout && (state != RUN)) begin
            state_nxt = RUN;
        end
        state_chg = (state_nxt != state);

        inc_press_ok = inc_rise && (state != RUN) && !state_chg;
        rep_hit      = rep_armed ? (rep_cnt == REP_W'(REPEAT_RATE - 1))
                                 : (rep_cnt == REP_W'(REPEAT_DELAY - 1));
        rep_fire     = inc_active && frame_en && inc_db_nxt && rep_hit && !state_chg;
        inc_fire     = inc_press_ok || rep_fire;

        blink_hit = (blink_cnt == BL_W'(BLINK_HALF - 1));
        phase_nxt = phase;
        if ((state_nxt == RUN) || state_chg)
            phase_nxt = 1'b0;
        else if (frame_en && blink_hit)
            phase_nxt = !phase;

        case (state_nxt)
            SET_HRS: field_sel = 3'b100;
            SET_MIN: field_sel = 3'b010;
            SET_SEC: field_sel = 3'b001;
            default: field_sel = 3'b000;
        endcase
        field_blank_nxt = (phase_nxt && !inc_db_nxt) ? field_sel : 3'b000;
    end

    always_ff @(posedge px_clk) begin
        if (reset) begin
            state       <= RUN;
            hold_tick   <= 1'b0;
            inc_hrs     <= 1'b0;
            inc_min     <= 1'b0;
            inc_sec     <= 1'b0;
            field_blank <= 3'b000;
            phase       <= 1'b0;
            blink_cnt   <= '0;
            idle_cnt    <= '0;
            inc_active  <= 1'b0;
            rep_armed   <= 1'b0;
            rep_cnt     <= '0;
        end else begin
            state       <= state_nxt;
            hold_tick   <= (state_nxt != RUN);
            inc_hrs     <= inc_fire && (state == SET_HRS);
            inc_min     <= inc_fire && (state == SET_MIN);
            inc_sec     <= inc_fire && (state == SET_SEC);
            field_blank <= field_blank_nxt;
            phase       <= phase_nxt;

            if ((state_nxt == RUN) || state_chg)
                blink_cnt <= '0;
            else if (frame_en)
                blink_cnt <= blink_hit ? '0 : blink_cnt + BL_W'(1);

            // Saturates at TIMEOUT_FRAMES; the state leaves on the next edge,
            // which clears it again.
            if ((state_nxt == RUN) || mode_rise || inc_rise || rep_fire)
                idle_cnt <= '0;
            else if (frame_en && (idle_cnt != TO_W'(TIMEOUT_FRAMES)))
                idle_cnt <= idle_cnt + TO_W'(1);

            if (inc_press_ok) begin
                inc_active <= 1'b1;
                rep_armed  <= 1'b0;
                rep_cnt    <= '0;
            end else if (state_chg || !inc_db_nxt) begin
                inc_active <= 1'b0;
                rep_armed  <= 1'b0;
                rep_cnt    <= '0;
            end else if (frame_en && inc_active) begin
                if (rep_hit) begin
                    rep_armed <= 1'b1;
                    rep_cnt   <= '0;
                end else begin
                    rep_cnt <= rep_cnt + REP_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_time_set_ctrl.sv
// -----------------------------------------------------------------------------
// tb_time_set_ctrl
//
// Directed stimulus for time_set_ctrl with a scoreboard. Stimulus pushes the
// expected increment pulses (which output, which frame) and expected status
// snapshots into queues; a monitor on the falling edge pops and compares
// whenever an inc output fires or a snapshot is requested.
// -----------------------------------------------------------------------------
module tb_time_set_ctrl;

    localparam int FRAME_LEN = 8;

    logic       px_clk = 1'b0;
    logic       reset;
    logic       frame_en;
    logic       btn_mode;
    logic       btn_inc;
    logic [1:0] mode;
    logic       hold_tick;
    logic       inc_hrs;
    logic       inc_min;
    logic       inc_sec;
    logic [2:0] field_blank;

    typedef struct packed {
        logic [1:0] mode;
        logic       hold;
        logic [2:0] blank;
        logic [2:0] inc;
    } status_t;

    logic [2:0] exp_pulse_vec[$];
    int         exp_pulse_frame[$];
    status_t    exp_status[$];
    string      exp_name[$];

    int   checks = 0;
    int   passes = 0;
    int   frames_issued = 0;
    int   frame_seen = 0;
    logic frame_was = 1'b0;
    logic snap_req = 1'b0;

    always #5 px_clk = ~px_clk;

    time_set_ctrl #(
        .DEBOUNCE_FRAMES (2),
        .REPEAT_DELAY    (4),
        .REPEAT_RATE     (2),
        .TIMEOUT_FRAMES  (10),
        .BLINK_HALF      (3)
    ) dut (
        .px_clk      (px_clk),
        .reset       (reset),
        .frame_en    (frame_en),
        .btn_mode    (btn_mode),
        .btn_inc     (btn_inc),
        .mode        (mode),
        .hold_tick   (hold_tick),
        .inc_hrs     (inc_hrs),
        .inc_min     (inc_min),
        .inc_sec     (inc_sec),
        .field_blank (field_blank)
    );

    always @(posedge px_clk) begin
        frame_was <= frame_en;
        if (frame_en)
            frame_seen <= frame_seen + 1;
    end

    always @(negedge px_clk) begin : monitor
        logic [2:0] act;
        logic [2:0] ev;
        int         ef;
        int         af;
        status_t    es;
        status_t    as;
        string      nm;
        act = {inc_hrs, inc_min, inc_sec};
        if (act != 3'b000) begin
            checks++;
            af = frame_was ? frame_seen : -1;
            if (exp_pulse_vec.size() == 0) begin
                $display("[TB] FAIL unexpected_pulse: got inc=%b after frame %0d, required no pulse", act, af);
            end else begin
                ev = exp_pulse_vec.pop_front();
                ef = exp_pulse_frame.pop_front();
                if ((act == ev) && (af == ef))
                    passes++;
                else
                    $display("[TB] FAIL pulse: got inc=%b after frame %0d, required inc=%b after frame %0d",
                             act, af, ev, ef);
            end
        end
        if (snap_req) begin
            checks++;
            as = '{mode: mode, hold: hold_tick, blank: field_blank, inc: act};
            if (exp_status.size() == 0) begin
                $display("[TB] FAIL snapshot: no expected status queued");
            end else begin
                es = exp_status.pop_front();
                nm = exp_name.pop_front();
                if (as == es)
                    passes++;
                else
                    $display("[TB] FAIL %s: got mode=%0d hold=%b blank=%b inc=%b, required mode=%0d hold=%b blank=%b inc=%b",
                             nm, as.mode, as.hold, as.blank, as.inc, es.mode, es.hold, es.blank, es.inc);
            end
        end
    end

    task automatic runFrame();
        repeat (FRAME_LEN - 1) @(posedge px_clk);
        #1 frame_en = 1'b1;
        @(posedge px_clk);
        #1 frame_en = 1'b0;
        frames_issued++;
    endtask

    task automatic applyStimulus(input logic m, input logic i, input int n);
        btn_mode = m;
        btn_inc  = i;
        repeat (n) runFrame();
    endtask

    task automatic pressMode();
        applyStimulus(1'b1, 1'b0, 3);
        applyStimulus(1'b0, 1'b0, 2);
    endtask

    task automatic expectPulse(input logic [2:0] v, input int f);
        exp_pulse_vec.push_back(v);
        exp_pulse_frame.push_back(f);
    endtask

    task automatic checkOutput(input string name, input logic [1:0] m, input logic h, input logic [2:0] b);
        exp_status.push_back('{mode: m, hold: h, blank: b, inc: 3'b000});
        exp_name.push_back(name);
        snap_req = 1'b1;
        @(posedge px_clk);
        #1 snap_req = 1'b0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no end of stimulus, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        reset    = 1'b1;
        frame_en = 1'b0;
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        repeat (3) @(posedge px_clk);
        #1 reset = 1'b0;
        checkOutput("reset_state", 2'd0, 1'b0, 3'b000);

        // Mode cycling through all states and back to RUN
        pressMode();
        checkOutput("mode_to_hrs", 2'd1, 1'b1, 3'b100);
        pressMode();
        checkOutput("mode_to_min", 2'd2, 1'b1, 3'b010);
        pressMode();
        checkOutput("mode_to_sec", 2'd3, 1'b1, 3'b001);
        pressMode();
        checkOutput("mode_to_run", 2'd0, 1'b0, 3'b000);

        // Auto-repeat in SET_MIN: press plus repeats after 4, 6, 8, 10 frames
        pressMode();
        pressMode();
        base = frames_issued;
        expectPulse(3'b010, base + 2);
        expectPulse(3'b010, base + 6);
        expectPulse(3'b010, base + 8);
        expectPulse(3'b010, base + 10);
        expectPulse(3'b010, base + 12);
        applyStimulus(1'b0, 1'b1, 11);
        checkOutput("min_inc_held_unblank", 2'd2, 1'b1, 3'b000);
        applyStimulus(1'b0, 1'b0, 2);
        checkOutput("min_after_release", 2'd2, 1'b1, 3'b010);

        // One-frame glitch in SET_SEC, then inc held in RUN
        pressMode();
        applyStimulus(1'b0, 1'b1, 1);
        applyStimulus(1'b0, 1'b0, 1);
        checkOutput("sec_after_glitch", 2'd3, 1'b1, 3'b001);
        applyStimulus(1'b0, 1'b0, 1);
        pressMode();
        checkOutput("back_to_run", 2'd0, 1'b0, 3'b000);
        applyStimulus(1'b0, 1'b1, 6);
        applyStimulus(1'b0, 1'b0, 2);
        checkOutput("run_inc_ignored", 2'd0, 1'b0, 3'b000);

        // Blink in SET_HRS and inactivity timeout after 10 frames
        pressMode();
        checkOutput("blink_hrs_on", 2'd1, 1'b1, 3'b100);
        applyStimulus(1'b0, 1'b0, 3);
        checkOutput("blink_hrs_off", 2'd1, 1'b1, 3'b000);
        applyStimulus(1'b0, 1'b0, 3);
        checkOutput("blink_hrs_on2", 2'd1, 1'b1, 3'b100);
        applyStimulus(1'b0, 1'b0, 1);
        checkOutput("timeout_edge", 2'd1, 1'b1, 3'b100);
        checkOutput("timeout_run", 2'd0, 1'b0, 3'b000);

        // Coincident mode and inc press in SET_HRS: mode wins, inc stays dead
        pressMode();
        applyStimulus(1'b1, 1'b1, 3);
        checkOutput("coincide_mode_wins", 2'd2, 1'b1, 3'b000);
        applyStimulus(1'b0, 1'b1, 4);
        applyStimulus(1'b0, 1'b0, 2);
        checkOutput("coincide_no_pulse", 2'd2, 1'b1, 3'b000);

        // Reset during auto-repeat in SET_MIN
        base = frames_issued;
        expectPulse(3'b010, base + 2);
        expectPulse(3'b010, base + 6);
        expectPulse(3'b010, base + 8);
        applyStimulus(1'b0, 1'b1, 9);
        repeat (2) @(posedge px_clk);
        #1 reset = 1'b1;
        @(posedge px_clk);
        #1 reset = 1'b0;
        checkOutput("reset_mid_repeat", 2'd0, 1'b0, 3'b000);
        applyStimulus(1'b0, 1'b1, 6);
        applyStimulus(1'b0, 1'b0, 2);
        checkOutput("after_reset_quiet", 2'd0, 1'b0, 3'b000);

        repeat (20) @(posedge px_clk);
        #1;
        checks++;
        if (exp_pulse_vec.size() == 0)
            passes++;
        else
            $display("[TB] FAIL missing_pulses: got %0d expected pulses unseen, required 0",
                     exp_pulse_vec.size());
        checks++;
        if (exp_status.size() == 0)
            passes++;
        else
            $display("[TB] FAIL missing_snapshots: got %0d snapshots unchecked, required 0",
                     exp_status.size());

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
